// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with byte-enabled writes,
// same-cycle write-to-read bypass, a pending-write scoreboard and a
// sweep-clear sequencer that zeroes every register on context reset.
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int NBE     = XLEN / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NBE-1:0]      wbe,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                ready
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rf [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic            wr_ok;
  logic            iss_ok;

  // Keep old bytes where the enable is low, take new bytes where it is high.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] new_v,
                                                  input logic [NBE-1:0]  be);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int k = 0; k < NBE; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  assign ready    = (state_q == IDLE);
  assign clr_busy = (state_q == SWEEP);

  // Register 0 is hard-wired when ZERO_REG is set, so it is never written or marked.
  assign wr_ok  = we && ready && !((ZERO_REG != 0) && (wa == '0));
  assign iss_ok = iss_valid && ready && !((ZERO_REG != 0) && (iss_addr == '0));

  // Sequencer state and sweep counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one clear per cycle, leaving after the last register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard update: a same-cycle issue to the written register wins over retire.
  always_comb begin
    busy_d = busy_q;
    if (state_q == IDLE) begin
      if (clr_req) begin
        busy_d = '0;
      end else begin
        if (we) busy_d[wa] = 1'b0;
        if (iss_ok) busy_d[iss_addr] = 1'b1;
      end
    end
  end

  // Busy bits register.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Register storage: reset clears all, sweep clears one per cycle, else byte write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else if (state_q == SWEEP) begin
      rf[cnt_q] <= '0;
    end else if (wr_ok) begin
      rf[wa] <= merge_bytes(rf[wa], wd, wbe);
    end
  end

  // Combinational read ports with write bypass; the sweep masks every port.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          zr;
    assign ra  = rd_addr[gi*AW +: AW];
    assign hit = we && ready && (wa == ra);
    assign zr  = (ZERO_REG != 0) && (ra == '0);
    assign rd_data[gi*XLEN +: XLEN] = clr_busy ? '0 :
                                      zr       ? '0 :
                                      hit      ? merge_bytes(rf[ra], wd, wbe) :
                                                 rf[ra];
    assign rd_busy[gi] = clr_busy ? 1'b1 : (busy_q[ra] && !hit);
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-read-port integer register file for the pipelined core. It is the successor to the fixed 32x32 two-read/one-write file and adds:
- width, depth and read-port-count generics
- byte-enabled writes
- same-cycle write-to-read bypass
- a per-register pending-write scoreboard for hazard detection
- a multi-cycle sweep-clear sequencer used on context reset

It sits between decode (reads, issue marking) and writeback (writes).

Parameters:
XLEN, 32, data width in bits; must be a multiple of 8.
NREGS, 32, number of registers; power of two, at least 2.
NRD, 2, number of combinational read ports, 1 to 4.
ZERO_REG, 1, when 1, register 0 always reads 0 and is never written or marked busy.
Derived constants: AW = log2(NREGS); NBE = XLEN/8.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset; one clock, reset sampled on the rising edge of clk.
rd_addr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
rd_data  out  NRD*XLEN  packed read data, combinational.
rd_busy  out  NRD  1 when the addressed register has a pending, un-retired write.
we  in  1  write enable.
wa  in  AW  write address.
wd  in  XLEN  write data.
wbe  in  NBE  byte enables; bit k gates wd[8k+7:8k].
iss_valid  in  1  marks iss_addr as pending (an instruction targeting it has issued).
iss_addr  in  AW  destination of the issuing instruction.
clr_req  in  1  single-cycle pulse; starts a sweep clear.
clr_busy  out  1  high while the sweep is in progress.
ready  out  1  equals !clr_busy; write and issue are accepted only when ready=1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all registers cleared to 0 and all busy bits cleared
  - sequencer to IDLE with the sweep counter at 0
  - clr_busy=0, ready=1
  - reset mid-sweep aborts the sweep with the same result.
- Write:
  - at the rising edge with we=1 and ready=1, for every k with wbe[k]=1: rf[wa] byte k <= wd byte k.
  - unenabled bytes are kept.
  - wa=0 is ignored when ZERO_REG=1.
  - wbe=0 writes no data but still retires busy (see scoreboard).
- Read (combinational, zero latency), per port i with address ra:
  - ra=0 and ZERO_REG=1 -> 0.
  - else if we=1, ready=1 and wa==ra -> bypass value: byte k = wd byte k if wbe[k], else rf[ra] byte k.
  - else -> rf[ra].
- Scoreboard (busy[NREGS], registered):
  - iss_valid=1 and ready=1 -> set busy[iss_addr].
  - we=1 and ready=1 -> clear busy[wa].
  - same address issued and written in the same cycle -> busy stays set (the newer issue wins).
  - reg 0 is never set when ZERO_REG=1.
  - rd_busy[i] = busy[ra] and not (we and ready and wa==ra); the bypass satisfies the read.
- Sweep sequencer:
  - states IDLE and SWEEP.
  - IDLE + clr_req=1 -> SWEEP; counter <= 0; all busy bits cleared on that edge.
  - SWEEP: each cycle rf[counter] <= 0 and counter increments.
  - at counter==NREGS-1, the final clear is written and the state returns to IDLE, so the sweep occupies exactly NREGS cycles.
  - clr_busy=1 in SWEEP.
  - clr_req in SWEEP is ignored.
  - we and iss_valid in SWEEP are dropped with no state change; the source stalls on ready.
  - during SWEEP, all rd_data read 0 and all rd_busy read 1.
- Width rules: addresses are unsigned and the counter is AW bits wide. There are no out-of-range addresses, since NREGS is a power of two.

Test Plan:
1. Reset, then read every address on all ports -> rd_data=0, rd_busy=0, ready=1, clr_busy=0.
2. Write wa=5, wd=0xDEADBEEF, wbe=0xF; next cycle write wa=5, wd=0x11223344, wbe=0x2, with rd_addr port0=5 in the same cycle -> bypass reads 0xDEAD33EF. After the edge, port1 at 5 reads 0xDEAD33EF.
3. Write wa=0, wd=0xFFFFFFFF, and issue iss_addr=0 -> port0 at 0 reads 0 and rd_busy=0 in every cycle.
4. Issue iss_addr=7 -> rd_busy for 7 goes to 1 next cycle. Write wa=7 with a simultaneous issue of 7 -> busy stays 1. A later write with no issue -> busy goes 0. Same-cycle write with read of 7 -> rd_busy=0 with bypass data.
5. Fill r1..r31 with nonzero values, busy on r3, pulse clr_req:
   - clr_busy=1 and ready=0 for exactly 32 cycles.
   - we pulses during this window are dropped; reads give 0 with busy=1.
   - afterwards all registers are 0 and no register is busy.
6. Start a sweep, assert rst_n=0 at cycle 10 -> next cycle clr_busy=0 and ready=1; all registers read 0.
